// File: rtl/spiflash_pkg.sv
`default_nettype none
// spiflash_pkg: shared state encoding and constants for the SPI flash read sequencer.
// Revision: 1.0
package spiflash_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_CS_SETUP = 3'd1,
    ST_SEND     = 3'd2,
    ST_GUARD    = 3'd3,
    ST_WAIT     = 3'd4,
    ST_NEXT     = 3'd5,
    ST_DONE     = 3'd6
  } state_t;

  localparam logic [7:0] c_READ_CMD   = 8'h03;
  localparam logic [7:0] c_DUMMY_BYTE = 8'h00;
  localparam int         c_SEQ_LEN    = 8;
  localparam logic [2:0] c_LAST_IDX   = 3'(c_SEQ_LEN - 1);

endpackage : spiflash_pkg
`default_nettype wire

// File: rtl/spiflash_reader.sv
`default_nettype none
// spiflash_reader: issues READ + 24-bit address + 4 dummy bytes and assembles a little-endian word.
// Revision: 1.0
module spiflash_reader
  import spiflash_pkg::*;
#(
  parameter logic [7:0] READ_CMD   = c_READ_CMD,
  parameter logic [7:0] DUMMY_BYTE = c_DUMMY_BYTE
) (
  input  logic        I_clk,
  input  logic        I_reset_n,
  input  logic        I_req,
  input  logic [23:0] I_addr,
  output logic [31:0] O_data,
  output logic        O_ack,
  output logic        O_busy,
  output logic        O_spi_cs_n,
  output logic [7:0]  O_spi_tx_data,
  output logic        O_spi_tx_start,
  input  logic [7:0]  I_spi_rx_data,
  input  logic        I_spi_busy
);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [2:0]  r_idx;
  logic [2:0]  w_idx_nxt;
  logic [23:0] r_addr;
  logic [23:0] r_word;
  logic [7:0]  w_tx_byte;
  logic        w_cs_active;

  logic [31:0] r_data;
  logic        r_ack;
  logic        r_busy;
  logic        r_cs_n;
  logic [7:0]  r_tx_data;
  logic        r_tx_start;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (I_req) begin
          w_state_nxt = ST_CS_SETUP;
          w_idx_nxt   = 3'd0;
        end
      end
      ST_CS_SETUP: w_state_nxt = ST_SEND;
      ST_SEND:     w_state_nxt = ST_GUARD;
      // Controller busy rises one cycle late, so it is not looked at here.
      ST_GUARD:    w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (!I_spi_busy) begin
          w_state_nxt = ST_NEXT;
        end
      end
      ST_NEXT: begin
        if (r_idx == c_LAST_IDX) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_SEND;
          w_idx_nxt   = r_idx + 3'd1;
        end
      end
      ST_DONE:     w_state_nxt = ST_IDLE;
      default:     w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_tx_byte = DUMMY_BYTE;
    case (w_idx_nxt)
      3'd0:    w_tx_byte = READ_CMD;
      3'd1:    w_tx_byte = r_addr[23:16];
      3'd2:    w_tx_byte = r_addr[15:8];
      3'd3:    w_tx_byte = r_addr[7:0];
      default: w_tx_byte = DUMMY_BYTE;
    endcase
  end

  assign w_cs_active = (w_state_nxt == ST_CS_SETUP) || (w_state_nxt == ST_SEND) ||
                       (w_state_nxt == ST_GUARD)    || (w_state_nxt == ST_WAIT) ||
                       (w_state_nxt == ST_NEXT);

  // Outputs are registered from the next state so they line up with the state they describe.
  always_ff @(posedge I_clk or negedge I_reset_n) begin
    if (!I_reset_n) begin
      r_state    <= ST_IDLE;
      r_idx      <= 3'd0;
      r_addr     <= 24'd0;
      r_word     <= 24'd0;
      r_data     <= 32'd0;
      r_ack      <= 1'b0;
      r_busy     <= 1'b0;
      r_cs_n     <= 1'b1;
      r_tx_data  <= 8'd0;
      r_tx_start <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_idx      <= w_idx_nxt;
      r_cs_n     <= !w_cs_active;
      r_tx_start <= (w_state_nxt == ST_SEND);
      r_busy     <= (w_state_nxt != ST_IDLE);
      r_ack      <= (w_state_nxt == ST_DONE);
      if (r_state == ST_IDLE && I_req) begin
        r_addr <= I_addr;
      end
      if (w_state_nxt == ST_SEND) begin
        r_tx_data <= w_tx_byte;
      end
      // Low bytes collect in a shadow so O_data only changes when the word is complete.
      if (r_state == ST_NEXT) begin
        case (r_idx)
          3'd4:    r_word[7:0]   <= I_spi_rx_data;
          3'd5:    r_word[15:8]  <= I_spi_rx_data;
          3'd6:    r_word[23:16] <= I_spi_rx_data;
          3'd7:    r_data        <= {I_spi_rx_data, r_word};
          default: ;
        endcase
      end
    end
  end

  assign O_data         = r_data;
  assign O_ack          = r_ack;
  assign O_busy         = r_busy;
  assign O_spi_cs_n     = r_cs_n;
  assign O_spi_tx_data  = r_tx_data;
  assign O_spi_tx_start = r_tx_start;

endmodule : spiflash_reader
`default_nettype wire
